// File: rtl/sweep_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and default sizing.
package sweep_pkg;

  localparam int unsigned N_IN_DEF        = 3;
  localparam int unsigned HOLD_CYCLES_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sweep_hold_counter.sv
// Hold-window counter: counts clocks while a vector is applied, flags the last cycle of the window.
module sweep_hold_counter
  import sweep_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(HOLD_CYCLES - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (clr)    r_cnt <= '0;
    else if (en)     r_cnt <= r_cnt + W'(1);
  end

  assign tc = (r_cnt == LAST);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps a function's input vector through every combination, captures its truth table
// and compares it against a reference.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int unsigned N_IN        = N_IN_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_f_out,
  input  logic [2**N_IN-1:0]   i_ref_table,
  output logic [N_IN-1:0]      o_vec,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2**N_IN-1:0]   o_table,
  output logic                 o_pass
);

  localparam logic [N_IN-1:0] VEC_LAST = '1;

  state_e              r_state;
  state_e              w_state_next;
  logic [N_IN-1:0]     r_vec;
  logic [2**N_IN-1:0]  r_table;
  logic                r_pass;
  logic [2**N_IN-1:0]  w_table_next;
  logic                w_tc;
  logic                w_accept;
  logic                w_sample;
  logic                w_last;

  assign w_accept = i_start && (r_state != ST_DRIVE);
  assign w_sample = (r_state == ST_DRIVE) && w_tc;
  assign w_last   = (r_vec == VEC_LAST);

  sweep_hold_counter #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_accept || w_sample),
    .en   (r_state == ST_DRIVE),
    .tc   (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_next = ST_DRIVE;
      ST_DRIVE: if (w_sample && w_last) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = i_start ? ST_DRIVE : ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == ST_DRIVE);
    o_done = (r_state == ST_DONE);
  end

  // Pass compares the table including the bit being captured on this same edge.
  always_comb begin
    w_table_next        = r_table;
    w_table_next[r_vec] = i_f_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec   <= '0;
      r_table <= '0;
      r_pass  <= 1'b0;
    end else if (w_accept) begin
      r_vec   <= '0;
      r_table <= '0;
      r_pass  <= 1'b0;
    end else if (w_sample) begin
      r_table <= w_table_next;
      if (w_last) r_pass <= (w_table_next == i_ref_table);
      else        r_vec  <= r_vec + N_IN'(1);
    end
  end

  assign o_vec   = r_vec;
  assign o_table = r_table;
  assign o_pass  = r_pass;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: default-hold and single-cycle-hold instances.
module tb_truth_table_sweeper;

  logic       clk;
  logic       rst_n;
  logic       start0, start1;
  logic       f_out0, f_out1;
  logic [7:0] ref0, ref1;
  logic [2:0] vec0, vec1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [7:0] table0, table1;

  int  total = 0;
  int  bad   = 0;
  int  tb_cyc = 0;
  int  start_cyc0 = 0;
  int  start_cyc1 = 0;
  int  rel0;
  bit  glitch_en;

  logic [8:0] q0[$];
  logic [8:0] q1[$];

  truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(10)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_start(start0), .i_f_out(f_out0), .i_ref_table(ref0),
    .o_vec(vec0), .o_busy(busy0), .o_done(done0), .o_table(table0), .o_pass(pass0)
  );

  truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start1), .i_f_out(f_out1), .i_ref_table(ref1),
    .o_vec(vec1), .o_busy(busy1), .o_done(done1), .o_table(table1), .o_pass(pass1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  // (a&b)|c, with an optional pulse on vec==2 that drops only in the sampling cycle
  assign rel0   = tb_cyc - start_cyc0;
  assign f_out0 = (glitch_en && vec0 == 3'd2) ? (rel0 >= 20 && rel0 <= 28)
                                              : ((vec0[2] & vec0[1]) | vec0[0]);
  assign f_out1 = ^vec1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done0) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL done0_unexpected t=%0t", $time);
      end else begin
        logic [8:0] e;
        e = q0.pop_front();
        chk("table0", table0, e[8:1]);
        chk("pass0", pass0, e[0]);
      end
    end
    if (rst_n && done1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL done1_unexpected t=%0t", $time);
      end else begin
        logic [8:0] e;
        e = q1.pop_front();
        chk("table1", table1, e[8:1]);
        chk("pass1", pass1, e[0]);
      end
    end
  end

  task automatic sweep0(input logic [7:0] r, input logic [7:0] exp_tbl, input logic exp_pass,
                        input bit pulse_mid);
    int rel;
    bit seen;
    ref0 = r;
    @(negedge clk);
    start0 = 1'b1;
    q0.push_back({exp_tbl, exp_pass});
    @(posedge clk);
    #1;
    start_cyc0 = tb_cyc;
    start0 = 1'b0;
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      rel = tb_cyc - start_cyc0;
      start0 = pulse_mid && (rel == 35);
      if (rel < 80 && (rel % 10 == 0 || rel % 10 == 9)) chk("vec0_hold", vec0, rel / 10);
      if (done0) begin
        seen = 1;
        chk("done0_latency", rel, 80);
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL done0_timeout act=none exp=done");
    end
    start0 = 1'b0;
    @(negedge clk);
    chk("done0_pulse", done0, 0);
    chk("busy0_idle", busy0, 0);
  endtask

  initial begin
    int rel;
    bit seen;
    clk = 0; rst_n = 0; start0 = 0; start1 = 0; glitch_en = 0;
    ref0 = 8'hEA; ref1 = 8'h96;
    repeat (3) @(negedge clk);
    chk("rst_vec0", vec0, 0);   chk("rst_busy0", busy0, 0); chk("rst_done0", done0, 0);
    chk("rst_table0", table0, 0); chk("rst_pass0", pass0, 0);
    chk("rst_vec1", vec1, 0);   chk("rst_busy1", busy1, 0); chk("rst_table1", table1, 0);
    rst_n = 1;
    repeat (3) @(negedge clk);

    sweep0(8'hEA, 8'hEA, 1'b1, 1'b0);
    sweep0(8'hEB, 8'hEA, 1'b0, 1'b1);
    glitch_en = 1;
    sweep0(8'hEA, 8'hEA, 1'b1, 1'b0);
    glitch_en = 0;

    // start held high: back-to-back sweeps
    ref0 = 8'hEA;
    @(negedge clk);
    start0 = 1'b1;
    q0.push_back({8'hEA, 1'b1});
    q0.push_back({8'hEA, 1'b1});
    @(posedge clk);
    #1;
    start_cyc0 = tb_cyc;
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      rel = tb_cyc - start_cyc0;
      if (done0) begin
        seen = 1;
        chk("held_done_latency1", rel, 80);
      end
    end
    if (!seen) begin total++; bad++; $display("FAIL held_timeout1 act=none exp=done"); end
    @(negedge clk);
    chk("restart_done", done0, 0);
    chk("restart_busy", busy0, 1);
    chk("restart_table", table0, 0);
    chk("restart_pass", pass0, 0);
    chk("restart_vec", vec0, 0);
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      rel = tb_cyc - start_cyc0;
      if (rel == 100) start0 = 1'b0;
      if (done0) begin
        seen = 1;
        chk("held_done_latency2", rel, 161);
      end
    end
    if (!seen) begin total++; bad++; $display("FAIL held_timeout2 act=none exp=done"); end
    start0 = 1'b0;
    @(negedge clk);
    chk("held_end_done", done0, 0);
    chk("held_end_busy", busy0, 0);

    // asynchronous reset in the middle of vec==3
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start_cyc0 = tb_cyc;
    start0 = 1'b0;
    repeat (36) @(negedge clk);
    chk("pre_rst_vec", vec0, 3);
    chk("pre_rst_table", table0, 8'h02);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_vec", vec0, 0);   chk("mid_rst_busy", busy0, 0); chk("mid_rst_done", done0, 0);
    chk("mid_rst_table", table0, 0); chk("mid_rst_pass", pass0, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", busy0, 0);
    chk("post_rst_vec", vec0, 0);
    chk("post_rst_table", table0, 0);

    // single-cycle hold instance
    @(negedge clk);
    start1 = 1'b1;
    q1.push_back({8'h96, 1'b1});
    @(posedge clk);
    #1;
    start_cyc1 = tb_cyc;
    start1 = 1'b0;
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      rel = tb_cyc - start_cyc1;
      if (rel < 8) chk("vec1_step", vec1, rel);
      if (done1) begin
        seen = 1;
        chk("done1_latency", rel, 8);
      end
    end
    if (!seen) begin total++; bad++; $display("FAIL done1_timeout act=none exp=done"); end
    @(negedge clk);
    chk("done1_pulse", done1, 0);
    chk("vec1_hold_last", vec1, 7);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture stage that sits directly upstream of a 3-input combinational function block (function_h).
- Steps the block's input vector {a,b,c} through all 2**N_IN combinations, holding each vector for HOLD_CYCLES clocks.
- Samples the function output at the end of each hold window and assembles the full truth table.
- Compares the table against a reference and reports pass/fail, replacing hand-written delay-based stimulus with a synthesizable sweep.

Parameters:
- N_IN, 3, number of function inputs; vec width; table width is 2**N_IN.
- HOLD_CYCLES, 10, clocks each vector is held before sampling; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a sweep; sampled on rising clk; accepted only in IDLE or DONE.
- f_out  input  1  output of the function under sweep (the `out` of function_h).
- ref_table  input  2**N_IN  expected truth table; bit i = expected output for vec==i; sampled on the DONE transition.
- vec  output  N_IN  drives function inputs; MSB = a, LSB = c for N_IN=3.
- busy  output  1  high while sweeping (DRIVE state).
- done  output  1  one-cycle pulse when the table is complete.
- table  output  2**N_IN  captured truth table; bit i = f_out sampled while vec==i.
- pass  output  1  registered (table == ref_table), updated with done; holds until the next start.

Behaviour:
- Reset (async, rst_n low): state=IDLE, vec=0, hold_cnt=0, busy=0, done=0, table=0, pass=0. Outputs follow reset immediately; a sweep in progress is discarded.
- States and transitions:
  - IDLE: start=1 -> DRIVE.
  - DRIVE: runs the sweep (below); the last sample -> DONE.
  - DONE: lasts exactly one cycle. start=1 -> DRIVE (immediate restart); otherwise -> IDLE.
- Start acceptance: on the accepting edge, vec<=0, hold_cnt<=0, table<=0, pass<=0, busy<=1.
- DRIVE sweep:
  - hold_cnt increments each clock.
  - At the edge where hold_cnt==HOLD_CYCLES-1: table[vec]<=f_out and hold_cnt<=0.
  - If vec==2**N_IN-1: state<=DONE, busy<=0, done<=1, pass<=({table with the new bit}==ref_table). Otherwise vec<=vec+1.
- Timing:
  - Each vector is stable for exactly HOLD_CYCLES cycles.
  - Total sweep is (2**N_IN)*HOLD_CYCLES cycles after the start edge.
  - done is high in the following cycle. Defaults: done high 80 edges after the start edge.
- HOLD_CYCLES=1: a new vector every clock; sampled at the edge ending its single cycle.
- start while busy: ignored, with no restart and no effect on the table.
- done deasserts in the cycle after DONE unless a restart occurs; in that case done=0 and busy=1 the next cycle.
- vec wrap: vec never increments past 2**N_IN-1; vec returns to 0 only on start or reset.
- In IDLE and DONE: vec holds its last value; table and pass hold until the next accepted start.
- f_out is sampled only at hold-window ends; glitches elsewhere are ignored.
- hold_cnt width: clog2(HOLD_CYCLES) bits, minimum 1.

Decomposition:
- Package sweep_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_DRIVE=2'd1, ST_DONE=2'd2;
  - default N_IN / HOLD_CYCLES constants.
- One natural sub-module: sweep_hold_counter.
  - Parameter HOLD_CYCLES.
  - Inputs clk, rst_n, clr, en.
  - Output tc, high when the count equals HOLD_CYCLES-1.
  - The top-level FSM owns vec, table and pass.

Test Plan:
- Reset: assert rst_n=0 mid-sweep at vec=3 -> vec=0, busy=0, done=0, table=8'h00, pass=0 immediately; after release, no activity until start.
- Full sweep, defaults: bench models f_out=(a&b)|c, ref_table=8'hEA, start pulse.
  - vec steps 0..7, each held 10 cycles.
  - done pulses once, 80 edges after start.
  - table=8'hEA, pass=1.
- Mismatch: same f_out, ref_table=8'hEB -> table=8'hEA, pass=0, done pulses once.
- HOLD_CYCLES=1, f_out=a^b^c -> vec changes every clock, done 8 edges after start, table=8'h96.
- start held high continuously (defaults): mid-sweep starts ignored; DONE->DRIVE restart gives back-to-back sweeps.
  - done is high for exactly one cycle per sweep.
  - table/pass cleared at each restart edge.
- f_out glitch: drive f_out=1 for hold cycles 0-8 of vec=2, then 0 on cycle 9 -> table[2]=0.
